// File: rtl/prpattern_pkg.sv
// Shared types for the pattern generator: mode and FSM encodings plus the
// maximal-length LFSR tap masks for widths 2..16.
package prpattern_pkg;

  typedef enum logic [1:0] {
    MODE_ALT_SHIFT = 2'd0,
    MODE_WALK      = 2'd1,
    MODE_COUNT     = 2'd2,
    MODE_LFSR      = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 16;

  // Bit n-1 of the mask corresponds to the x^n term of the feedback polynomial.
  function automatic logic [15:0] lfsr_taps(input int width);
    logic [15:0] taps;
    case (width)
      2:       taps = 16'h0003; // x^2+x+1
      3:       taps = 16'h0006; // x^3+x^2+1
      4:       taps = 16'h000C; // x^4+x^3+1
      5:       taps = 16'h0014;
      6:       taps = 16'h0030;
      7:       taps = 16'h0060;
      8:       taps = 16'h00B8;
      9:       taps = 16'h0110;
      10:      taps = 16'h0240;
      11:      taps = 16'h0500;
      12:      taps = 16'h0829;
      13:      taps = 16'h100D;
      14:      taps = 16'h2015;
      15:      taps = 16'h6000;
      16:      taps = 16'hD008;
      default: taps = 16'h000C;
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/prpattern_lfsr.sv
// Combinational next state of a Fibonacci shift-left LFSR; the all-zero
// lock-up state is forced to 1 so the sequence always restarts.
module prpattern_lfsr
  import prpattern_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] state_i,
  output logic [WIDTH-1:0] next_o
);

  localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] tapped;
  logic             feedback;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_tap
    assign tapped[gi] = state_i[gi] & TAPS[gi];
  end

  assign feedback = ^tapped;
  assign next_o   = (state_i == '0) ? ONE : {state_i[WIDTH-2:0], feedback};

endmodule

// File: rtl/prpattern_gen.sv
// Prescaled multi-mode pattern generator with seed load and step/wrap pulses.
// Define PRPAT_LFSR_EN to compile in the LFSR mode; otherwise mode 3 holds data.
module prpattern_gen
  import prpattern_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DIV_W = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] data,
  output logic             step,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DIV_W-1:0] CNT_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  mode_e            mode_q,  mode_d;
  logic [WIDTH-1:0] seed_q,  seed_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [DIV_W-1:0] cnt_q,   cnt_d;
  logic             phase_q, phase_d;
  logic             step_q,  step_d;
  logic             wrap_q,  wrap_d;

  logic             tick;
  logic [WIDTH-1:0] pattern_next;

  // A tick needs en still high: dropping en suppresses the step on that edge.
  assign tick = (state_q == ST_RUN) && en && (cnt_q == div);

`ifdef PRPAT_LFSR_EN
  logic [WIDTH-1:0] lfsr_next;

  prpattern_lfsr #(
    .WIDTH (WIDTH)
  ) u_lfsr (
    .state_i (data_q),
    .next_o  (lfsr_next)
  );
`endif

  always_comb begin
    pattern_next = data_q;
    case (mode_q)
      MODE_ALT_SHIFT: pattern_next = {data_q[WIDTH-2:0], phase_q};
      MODE_WALK:      pattern_next = (data_q == '0) ? ONE
                                   : {data_q[WIDTH-2:0], data_q[WIDTH-1]};
      MODE_COUNT:     pattern_next = data_q + ONE;
`ifdef PRPAT_LFSR_EN
      MODE_LFSR:      pattern_next = lfsr_next;
`else
      MODE_LFSR:      pattern_next = data_q;
`endif
      default:        pattern_next = data_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    seed_d  = seed_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    step_d  = tick;
    wrap_d  = tick && (pattern_next == seed_q);

    case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        mode_d = mode_e'(mode);
        if (en) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!en) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (tick) begin
          cnt_d  = '0;
          data_d = pattern_next;
          if (mode_q == MODE_ALT_SHIFT) begin
            phase_d = ~phase_q;
          end
        end else begin
          // Free-running wrap keeps a shrunken div glitch-free.
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      state_d = state_q;
      mode_d  = mode_e'(mode);
      seed_d  = seed;
      data_d  = seed;
      cnt_d   = '0;
      phase_d = 1'b0;
      step_d  = 1'b0;
      wrap_d  = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_ALT_SHIFT;
      seed_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      seed_q  <= seed_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
    end
  end

  assign data = data_q;
  assign step = step_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_prpattern_gen.sv
// Directed + randomized bench for prpattern_gen against a behavioural model.
module tb_prpattern_gen;

  localparam int W  = 4;
  localparam int DW = 3;
  localparam int LFSR_TAPS = 12; // x^4 + x^3 + 1

  logic          clk;
  logic          rst;
  logic          en;
  logic [1:0]    mode;
  logic [DW-1:0] div;
  logic          load;
  logic [W-1:0]  seed;
  logic [W-1:0]  data;
  logic          step;
  logic          wrap;

  int tests;
  int fails;

  // Behavioural model state
  int m_data, m_seed, m_mode, m_phase, m_cnt;
  bit m_run;
  int e_step, e_wrap;

  prpattern_gen #(.WIDTH(W), .DIV_W(DW)) dut (
    .CLK  (clk),
    .RST  (rst),
    .en   (en),
    .mode (mode),
    .div  (div),
    .load (load),
    .seed (seed),
    .data (data),
    .step (step),
    .wrap (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int next_pat(input int d, input int md, input int ph);
    int m;
`ifdef PRPAT_LFSR_EN
    int p;
`endif
    m = 1 << W;
    case (md)
      0: return (d * 2) % m + ph;
      1: return (d == 0) ? 1 : (d * 2) % m + d / (m / 2);
      2: return (d + 1) % m;
      default: begin
`ifdef PRPAT_LFSR_EN
        if (d == 0) return 1;
        p = 0;
        for (int b = 0; b < W; b++)
          if (((LFSR_TAPS >> b) & 1) != 0) p = p ^ ((d >> b) & 1);
        return (d * 2) % m + p;
`else
        return d;
`endif
      end
    endcase
  endfunction

  task automatic model_reset();
    m_data = 0; m_seed = 0; m_mode = 0; m_phase = 0; m_cnt = 0; m_run = 1'b0;
    e_step = 0; e_wrap = 0;
  endtask

  // Advance one clock: predict from the inputs in force, then compare after the edge.
  task automatic cycle(input string tag);
    int  nd;
    bit  tk;
    tk = m_run && en && (m_cnt == int'(div));
    nd = next_pat(m_data, m_mode, m_phase);
    e_step = 0;
    e_wrap = 0;
    if (load) begin
      m_data = int'(seed); m_seed = int'(seed); m_mode = int'(mode);
      m_phase = 0; m_cnt = 0;
    end else if (!m_run) begin
      m_cnt = 0; m_mode = int'(mode); m_run = en;
    end else if (!en) begin
      m_run = 1'b0; m_cnt = 0;
    end else if (tk) begin
      m_data = nd;
      if (m_mode == 0) m_phase = 1 - m_phase;
      m_cnt = 0; e_step = 1; e_wrap = (nd == m_seed) ? 1 : 0;
    end else begin
      m_cnt = (m_cnt + 1) % (1 << DW);
    end
    @(posedge clk);
    #1;
    chk({tag, "/data"}, 32'(data), 32'(m_data));
    chk({tag, "/step"}, 32'(step), 32'(e_step));
    chk({tag, "/wrap"}, 32'(wrap), 32'(e_wrap));
    if (step || load)
      $display("[TB] %0t %s data=%b step=%b wrap=%b", $time, tag, data, step, wrap);
  endtask

  int exp_alt [6] = '{0, 1, 2, 5, 10, 5};
  int exp_wrap[6] = '{1, 0, 0, 0, 0, 0};
  int exp_walk[5] = '{1, 2, 4, 8, 1};
  bit seen[16];
  int ndistinct, nsteps;

  initial begin
    tests = 0; fails = 0;
    rst = 1'b1; en = 1'b0; mode = 2'd0; div = '0; load = 1'b0; seed = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset/data", 32'(data), 0);
    chk("reset/step", 32'(step), 0);
    chk("reset/wrap", 32'(wrap), 0);
    rst = 1'b0;

    // ALT_SHIFT from reset, div=0
    en = 1'b1;
    cycle("t1_enter");
    for (int i = 0; i < 6; i++) begin
      cycle("t1_alt");
      chk("t1_alt_const", 32'(data), 32'(exp_alt[i]));
      chk("t1_wrap_const", 32'(wrap), 32'(exp_wrap[i]));
    end

    // WALK with seed 0
    en = 1'b0; cycle("t2_idle");
    mode = 2'd1; seed = 4'b0000; load = 1'b1; cycle("t2_load");
    load = 1'b0; en = 1'b1; cycle("t2_enter");
    for (int i = 0; i < 5; i++) begin
      cycle("t2_walk");
      chk("t2_walk_const", 32'(data), 32'(exp_walk[i]));
      chk("t2_nowrap", 32'(wrap), 0);
    end

    // COUNT, div=2, seed 1110: wraps on step 16
    en = 1'b0; cycle("t3_idle");
    mode = 2'd2; div = 3'd2; seed = 4'b1110; load = 1'b1; cycle("t3_load");
    load = 1'b0; en = 1'b1; cycle("t3_enter");
    for (int i = 0; i < 48; i++) cycle("t3_count");
    chk("t3_step16_data", 32'(data), 32'h0000000E);
    chk("t3_step16_wrap", 32'(wrap), 1);

    // LFSR / hold mode, seed 0001, div=0
    en = 1'b0; cycle("t4_idle");
    mode = 2'd3; div = 3'd0; seed = 4'b0001; load = 1'b1; cycle("t4_load");
    load = 1'b0; en = 1'b1; cycle("t4_enter");
    foreach (seen[i]) seen[i] = 1'b0;
    ndistinct = 0;
    for (int i = 1; i <= 15; i++) begin
      cycle("t4_lfsr");
`ifdef PRPAT_LFSR_EN
      if (!seen[data]) ndistinct++;
      seen[data] = 1'b1;
      chk("t4_wrap_pos", 32'(wrap), (i == 15) ? 1 : 0);
`else
      chk("t4_hold", 32'(data), 1);
      chk("t4_wrap_each", 32'(wrap), 1);
`endif
    end
`ifdef PRPAT_LFSR_EN
    chk("t4_distinct", 32'(ndistinct), 15);
    chk("t4_no_zero", 32'(seen[0]), 0);
`endif

    // load coincident with a tick, div=2
    div = 3'd2; mode = 2'd2; seed = 4'b0011; load = 1'b1; cycle("t5_preload");
    load = 1'b0;
    for (int i = 0; i < 16 && m_cnt != int'(div); i++) cycle("t5_align");
    chk("t5_aligned", 32'(m_cnt), 32'(div));
    seed = 4'b1010; load = 1'b1; cycle("t5_load_tick");
    chk("t5_load_data", 32'(data), 32'h0000000A);
    chk("t5_load_step", 32'(step), 0);
    load = 1'b0;
    cycle("t5_wait1"); cycle("t5_wait2"); cycle("t5_next");
    chk("t5_next_step", 32'(step), 1);
    chk("t5_next_data", 32'(data), 32'h0000000B);

    // async reset between edges while running
    cycle("t6_run");
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_data", 32'(data), 0);
    chk("t6_rst_step", 32'(step), 0);
    chk("t6_rst_wrap", 32'(wrap), 0);
    model_reset();
    #2 rst = 1'b0;
    cycle("t6_enter");
    cycle("t6_w1"); cycle("t6_w2"); cycle("t6_first");
    chk("t6_first_step", 32'(step), 1);
    chk("t6_first_data", 32'(data), 1);

    // shrink div below the running count
    div = 3'd7;
    for (int i = 0; i < 6; i++) cycle("t7_slow");
    div = 3'd2;
    nsteps = 0;
    for (int i = 0; i < 12; i++) begin
      cycle("t7_shrink");
      nsteps += int'(step);
    end
    chk("t7_steps_seen", 32'(nsteps > 0), 1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      en   = ($urandom_range(0, 9) != 0);
      mode = 2'($urandom_range(0, 3));
      load = ($urandom_range(0, 19) == 0);
      seed = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) div = 3'($urandom_range(0, 7));
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/prpattern_gen.md
# prpattern_gen

Parametrised pattern generator for the partially-reconfigurable region. It is the next generation of the fixed 4-bit alternating shift pattern, and adds:
- configurable width and step-rate prescaler,
- four selectable pattern modes,
- seed load,
- step and wrap status pulses.

It sits inside the PR partition and drives LED/IO test patterns and PL→PS handshake signals.

## Interface
- WIDTH, 4, pattern width; legal range 2..16.
- DIV_W, 3, prescaler counter width.
- CLK  in  1  clock; all state on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- en  in  1  level; run enable.
- mode  in  2  pattern select: 0 ALT_SHIFT, 1 WALK, 2 COUNT, 3 LFSR.
- div  in  DIV_W  step period minus one; a step occurs every div+1 cycles.
- load  in  1  one-cycle pulse; load seed.
- seed  in  WIDTH  value loaded on load.
- data  out  WIDTH  current pattern, registered.
- step  out  1  one-cycle pulse, high in the cycle new data is first visible.
- wrap  out  1  one-cycle pulse with step when the new data equals the stored seed.

## Operation
- Internal state: FSM {IDLE, RUN}, mode_q, seed_q, phase bit, prescaler cnt.
- IDLE:
  - data holds, cnt held at 0, mode_q <= mode every cycle.
  - en=1 → RUN.
- RUN:
  - mode input is ignored; mode_q changes only on load.
  - cnt counts 0..div, then returns to 0.
  - tick = (cnt==div).
  - en=0 → IDLE next edge; no tick occurs on that edge.
- On tick, data updates per mode_q:
  - ALT_SHIFT: data <= {data[WIDTH-2:0], phase}, then phase toggles.
  - WALK: rotate left by 1; if data==0, data <= 1.
  - COUNT: data <= data+1, modulo 2^WIDTH.
  - LFSR: Fibonacci XOR shift-left with the package tap mask for WIDTH; if data==0, data <= 1.
- load, any state, highest priority:
  - data <= seed, seed_q <= seed, mode_q <= mode, phase <= 0, cnt <= 0.
  - A coincident tick is discarded; step=0 and wrap=0 that cycle.
  - FSM state is unchanged.
- step <= tick & !load.
- wrap <= tick & !load & (next data == seed_q).
- Reset values: data=0, step=0, wrap=0, state=IDLE, mode_q=0, seed_q=0, phase=0, cnt=0.
- RST mid-run: all state clears immediately; no partial step is retained.
- Changing div in RUN takes effect immediately. If cnt > new div, cnt counts up and wraps through 2^DIV_W before the next tick (defined, non-glitching).

## Timing
- en first sampled high at edge k → RUN from k. The first tick is at edge k+1+div, and data and step change at that edge.
- Step latency thereafter is exactly div+1 cycles.
- data is valid in the cycle immediately after load is sampled.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- PRPAT_LFSR_EN defined: LFSR mode and the tap table are compiled in.
- PRPAT_LFSR_EN undefined:
  - mode 3 holds data on tick.
  - step still pulses; wrap fires only when data == seed_q.
  - No LFSR logic is synthesised.

## Structure
- Package prpattern_pkg contains:
  - mode enum (ALT_SHIFT, WALK, COUNT, LFSR),
  - FSM state enum,
  - LFSR tap-mask function/table indexed by WIDTH 2..16 (maximal-length; WIDTH 4 = x^4+x^3+1).
- Sub-module prpattern_lfsr: combinational next-state of the LFSR, parametrised by WIDTH. It is instantiated only under PRPAT_LFSR_EN.

## Test plan
- Reset, mode=0, div=0, en=1 → data 0000, then per cycle 0000, 0001, 0010, 0101, 1010, 0101; step high each update; wrap pulses only on the first update (0000==seed_q).
- mode=1, load seed=0000, div=0, run → 0001, 0010, 0100, 1000, 0001; wrap never fires (seed 0).
- mode=2, div=2, load seed=1110, run → steps every 3 cycles: 1111, 0000, ..., 1110 on step 16 with wrap=1.
- mode=3, seed=0001, div=0, macro on → 15 distinct nonzero values, wrap on step 15. Macro off → data stays 0001 and wrap on every step.
- load asserted on a tick edge with seed=1010 → data=1010, step=0; the next step is div+1 cycles later.
- RST asserted mid-RUN between edges → data, step, wrap go to 0 immediately; en must be re-sampled, and the first step comes div+1 cycles after RUN is entered.
